multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Parametrised successor to the 13-opcode multicycle control unit of the 16-bit processor. It adds a memory wait-state handshake (mem_ready), a SYSCALL halt/resume state, trapping of illegal opcodes, and a retired-instruction counter. It sits between the IR opcode field and the datapath muxes/write enables, and exposes current_state/next_state for debug.

Parameters:
OPCODE_W, 6, opcode field width; valid opcodes are 0..12 (zero-extended compare); anything else is illegal.
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
TRAP_ON_ILLEGAL, 1, 1 = illegal opcode enters TRAP; 0 = illegal opcode is a NOP (DECODE goes to FETCH).
CNT_W, 16, width of retired_count.

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
Opcode  in  OPCODE_W  IR opcode field, stable from DECODE onward
mem_ready  in  1  memory access completes this cycle
resume  in  1  leave HALT/TRAP
ALUOp  out  2  0 add, 1 sub, 2 funct
ALUSrcA  out  1  0 PC, 1 A reg
ALUSrcB  out  3  0 B reg, 1 const 1, 2 sign-ext imm
WriteSrc  out  3  0 ALUOut, 1 PC, 2 upper imm, 3 lower imm, 4 CR, 5 MDR
WriteDest  out  2  0 rd, 1 rt, 2 ra
CRWrite, RegWrite, MemRead, MemWrite, IorD, IRWrite, PCWrite, isBranch  out  1 each  datapath strobes/selects
PCSrc  out  2  0 ALU, 1 ALUOut (branch), 2 jump target, 3 register
current_state, next_state  out  4  state register / next-state logic
halted, illegal_op  out  1  in HALT / in TRAP
instr_done  out  1  one-cycle retire pulse
retired_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Outputs are combinational from current_state and Opcode. Any signal not listed for a state is 0.
- Reset: the state register becomes FETCH(0) and retired_count becomes 0 at the clock edge. While Reset=1: all strobes, instr_done, halted and illegal_op are forced 0, and next_state=0. Reset asserted in any state, including mid-wait, aborts the instruction.
- rdy = mem_ready | ~MEM_WAIT_EN.
- State 0 FETCH: MemRead=1, ALUSrcB=1, ALUOp=0, PCSrc=0, and IRWrite=PCWrite=rdy. Stays in FETCH while !rdy, otherwise goes to DECODE.
- State 1 DECODE: ALUSrcB=2 (branch target precompute). Next state by opcode:
  - 0 → CEXEC
  - 1, 2 → BRANCH
  - 3, 4, 5 → JUMP
  - 6, 7 → LOADIMM
  - 8, 9 → CRMOVE
  - 10, 11 → MEMADDR
  - 12 → HALT
  - other → TRAP, or FETCH if TRAP_ON_ILLEGAL=0
- State 2 CEXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. → 3.
- State 3 CWB: RegWrite=1, WriteSrc=0, WriteDest=0. → FETCH.
- State 4 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, isBranch=1, PCSrc=1. → FETCH.
- State 5 JUMP: PCWrite=1. PCSrc=3 for opcode 5, else PCSrc=2. Opcode 4 also asserts RegWrite=1, WriteSrc=1, WriteDest=2. → FETCH.
- State 6 LOADIMM: RegWrite=1, WriteDest=1, WriteSrc=2 (opcode 6) or 3 (opcode 7). → FETCH.
- State 7 CRMOVE: opcode 8 asserts RegWrite=1, WriteSrc=4, WriteDest=1; opcode 9 asserts CRWrite=1. → FETCH.
- State 8 MEMADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. → 9 if opcode 10, → 10 if opcode 11.
- State 9 MEMRD: MemRead=1, IorD=1. Stays while !rdy, then → 11.
- State 10 MEMWR: MemWrite=1, IorD=1. Stays while !rdy, then → FETCH. MemWrite stays high for every wait cycle.
- State 11 LWB: RegWrite=1, WriteSrc=5, WriteDest=1. → FETCH.
- State 12 HALT: halted=1. Stays until resume=1, then → FETCH.
- State 13 TRAP: illegal_op=1. Stays until resume=1, then → FETCH. A TRAP exit does not retire.
- States 14 and 15 are unreachable; if entered, next_state=FETCH with no strobes.
- instr_done=1 on the cycle the FSM leaves states 3, 4, 5, 6, 7, 10, 11 or 12 for FETCH. retired_count increments by 1 on that edge and wraps from 2^CNT_W−1 to 0.
- resume is ignored outside HALT/TRAP. mem_ready is ignored outside states 0, 9 and 10.
- Latency with rdy=1 throughout:
  - 3 cycles: BRANCH, JUMP, LOADIMM, CRMOVE
  - 4 cycles: C-type, SW
  - 5 cycles: LW

Test Plan:
1. Reset=1 for 5 cycles, then Opcode=0, release Reset, mem_ready=1 → states 0,1,2,3,0. RegWrite=1 only in state 3. instr_done pulses once; retired_count=1.
2. Opcode=10, mem_ready low for 3 cycles in MEMRD → states 0,1,8,9,9,9,9,11,0. MemRead=IorD=1 in all four state-9 cycles. WriteSrc=5 in state 11.
3. Opcode=4 → JUMP asserts PCWrite=1, PCSrc=2, RegWrite=1, WriteSrc=1, WriteDest=2. Opcode=5 → PCSrc=3, RegWrite=0.
4. Opcode=12, resume held 0 for 4 cycles then 1 → halted=1 throughout state 12. Return to FETCH; retired_count +1. Opcode=13 → TRAP with illegal_op=1; after resume, retired_count is unchanged. With TRAP_ON_ILLEGAL=0: DECODE→FETCH, no count.
5. CNT_W=2, run 5 Opcode=6 instructions → retired_count sequence 1,2,3,0,1.
6. Assert Reset during a state-10 wait → next edge current_state=0, MemWrite=0 while Reset=1, retired_count=0. MEM_WAIT_EN=0 with mem_ready=0 → no stalls.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for the 16-bit processor: 13-opcode decode,
// memory wait states, HALT/resume, illegal-opcode trap, retire counter.
module multicycle_control_fsm #(
  parameter int OPCODE_W        = 6,
  parameter bit MEM_WAIT_EN     = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                mem_ready,
  input  logic                resume,
  output logic [1:0]          ALUOp,
  output logic                ALUSrcA,
  output logic [2:0]          ALUSrcB,
  output logic [2:0]          WriteSrc,
  output logic [1:0]          WriteDest,
  output logic                CRWrite,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IorD,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                isBranch,
  output logic [1:0]          PCSrc,
  output logic [3:0]          current_state,
  output logic [3:0]          next_state,
  output logic                halted,
  output logic                illegal_op,
  output logic                instr_done,
  output logic [CNT_W-1:0]    retired_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_CEXEC = 4'd2,  S_CWB    = 4'd3,
    S_BRANCH  = 4'd4,  S_JUMP   = 4'd5,  S_LOADIMM = 4'd6, S_CRMOVE = 4'd7,
    S_MEMADDR = 4'd8,  S_MEMRD  = 4'd9,  S_MEMWR = 4'd10, S_LWB    = 4'd11,
    S_HALT    = 4'd12, S_TRAP   = 4'd13, S_RSV14 = 4'd14, S_RSV15  = 4'd15
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   retired_count_q, retired_count_d;
  logic [31:0]        op_ext;
  logic               rdy;

  // Opcodes compare zero-extended so narrow/wide opcode fields behave alike.
  assign op_ext = 32'(Opcode);
  // With wait states disabled every memory access completes immediately.
  assign rdy    = mem_ready | ~MEM_WAIT_EN;

  // Next-state and datapath controls; Reset forces everything quiet and FETCH.
  always_comb begin
    state_d    = S_FETCH;
    ALUOp      = 2'd0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 3'd0;
    WriteSrc   = 3'd0;
    WriteDest  = 2'd0;
    CRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    isBranch   = 1'b0;
    PCSrc      = 2'd0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    if (!Reset) begin
      state_d = state_q;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 3'd1;
          IRWrite = rdy;
          PCWrite = rdy;
          if (rdy) state_d = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB = 3'd2;  // precompute branch target
          if      (op_ext == 32'd0)  state_d = S_CEXEC;
          else if (op_ext <= 32'd2)  state_d = S_BRANCH;
          else if (op_ext <= 32'd5)  state_d = S_JUMP;
          else if (op_ext <= 32'd7)  state_d = S_LOADIMM;
          else if (op_ext <= 32'd9)  state_d = S_CRMOVE;
          else if (op_ext <= 32'd11) state_d = S_MEMADDR;
          else if (op_ext == 32'd12) state_d = S_HALT;
          else if (TRAP_ON_ILLEGAL)  state_d = S_TRAP;
          else                       state_d = S_FETCH;
        end
        S_CEXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'd2;
          state_d = S_CWB;
        end
        S_CWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUOp      = 2'd1;
          isBranch   = 1'b1;
          PCSrc      = 2'd1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = (op_ext == 32'd5) ? 2'd3 : 2'd2;
          if (op_ext == 32'd4) begin  // jump-and-link writes PC to ra
            RegWrite  = 1'b1;
            WriteSrc  = 3'd1;
            WriteDest = 2'd2;
          end
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_LOADIMM: begin
          RegWrite   = 1'b1;
          WriteDest  = 2'd1;
          WriteSrc   = (op_ext == 32'd6) ? 3'd2 : 3'd3;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_CRMOVE: begin
          if (op_ext == 32'd8) begin
            RegWrite  = 1'b1;
            WriteSrc  = 3'd4;
            WriteDest = 2'd1;
          end
          if (op_ext == 32'd9) CRWrite = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 3'd2;
          if      (op_ext == 32'd10) state_d = S_MEMRD;
          else if (op_ext == 32'd11) state_d = S_MEMWR;
          else                       state_d = S_FETCH;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (rdy) state_d = S_LWB;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;  // held through every wait cycle
          IorD     = 1'b1;
          if (rdy) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_LWB: begin
          RegWrite   = 1'b1;
          WriteSrc   = 3'd5;
          WriteDest  = 2'd1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
          if (resume) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_TRAP: begin
          illegal_op = 1'b1;  // leaving a trap does not retire
          if (resume) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;  // unreachable encodings recover
      endcase
    end
  end

  // Retire counter advances on each retire pulse and wraps naturally.
  always_comb begin
    retired_count_d = retired_count_q + CNT_W'(instr_done);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Retired-instruction counter register.
  always_ff @(posedge CLK) begin
    if (Reset) retired_count_q <= '0;
    else       retired_count_q <= retired_count_d;
  end

  assign current_state = state_q;
  assign next_state    = state_d;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm. Two instances run side by side:
// u0 with defaults, u1 with wait states off, illegal-as-NOP and a 2-bit
// counter. An instruction-level route model predicts every cycle.
module tb_multicycle_control_fsm;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst [2];
  logic [5:0] opc [2];
  logic       mr  [2];
  logic       res [2];

  logic [1:0] aluop [2], pcsrc [2], wdest [2];
  logic [2:0] srcb [2], wsrc [2];
  logic       srca [2], crw [2], rw [2], mrd [2], mwr [2], iord [2];
  logic       irw [2], pcw [2], isbr [2], hlt [2], ill [2], idone [2];
  logic [3:0] cs [2], ns [2];
  logic [15:0] rc0;
  logic [1:0]  rc1;

  multicycle_control_fsm #(.OPCODE_W(6), .MEM_WAIT_EN(1'b1), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(16)) u0 (
    .CLK(CLK), .Reset(rst[0]), .Opcode(opc[0]), .mem_ready(mr[0]), .resume(res[0]),
    .ALUOp(aluop[0]), .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]), .WriteSrc(wsrc[0]),
    .WriteDest(wdest[0]), .CRWrite(crw[0]), .RegWrite(rw[0]), .MemRead(mrd[0]),
    .MemWrite(mwr[0]), .IorD(iord[0]), .IRWrite(irw[0]), .PCWrite(pcw[0]),
    .isBranch(isbr[0]), .PCSrc(pcsrc[0]), .current_state(cs[0]), .next_state(ns[0]),
    .halted(hlt[0]), .illegal_op(ill[0]), .instr_done(idone[0]), .retired_count(rc0));

  multicycle_control_fsm #(.OPCODE_W(6), .MEM_WAIT_EN(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(2)) u1 (
    .CLK(CLK), .Reset(rst[1]), .Opcode(opc[1]), .mem_ready(mr[1]), .resume(res[1]),
    .ALUOp(aluop[1]), .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]), .WriteSrc(wsrc[1]),
    .WriteDest(wdest[1]), .CRWrite(crw[1]), .RegWrite(rw[1]), .MemRead(mrd[1]),
    .MemWrite(mwr[1]), .IorD(iord[1]), .IRWrite(irw[1]), .PCWrite(pcw[1]),
    .isBranch(isbr[1]), .PCSrc(pcsrc[1]), .current_state(cs[1]), .next_state(ns[1]),
    .halted(hlt[1]), .illegal_op(ill[1]), .instr_done(idone[1]), .retired_count(rc1));

  // Per-instance configuration as seen by the model.
  int wait_en [2] = '{1, 0};
  int trap_en [2] = '{1, 0};
  int cmod    [2] = '{65536, 4};

  // Model: each instruction is a route of states; wait states hold position.
  int route   [2][6];
  int len     [2];
  int pos     [2];
  bit retires [2];
  int cnt     [2];

  int ncmp = 0;
  int nerr = 0;

  task automatic restart(input int d);
    route[d][0] = 0; route[d][1] = 1; len[d] = 2; pos[d] = 0; retires[d] = 1'b1;
  endtask

  task automatic add(input int d, input int s);
    route[d][len[d]] = s;
    len[d]++;
  endtask

  // Route tail chosen by opcode class once the instruction is in DECODE.
  task automatic build_tail(input int d, input int op);
    retires[d] = 1'b1;
    if      (op == 0)  begin add(d, 2); add(d, 3); end
    else if (op <= 2)  add(d, 4);
    else if (op <= 5)  add(d, 5);
    else if (op <= 7)  add(d, 6);
    else if (op <= 9)  add(d, 7);
    else if (op == 10) begin add(d, 8); add(d, 9); add(d, 11); end
    else if (op == 11) begin add(d, 8); add(d, 10); end
    else if (op == 12) add(d, 12);
    else begin
      retires[d] = 1'b0;
      if (trap_en[d] != 0) add(d, 13);
    end
  endtask

  // Control word expected in state st; packed in the same order as 'act'.
  function automatic logic [23:0] exp_out(input int st, input int op, input bit rdy,
                                          input bit done, input bit r);
    logic [1:0] a_op, pcs, wd;
    logic [2:0] sb, ws;
    logic sa, cr, rwr, mrdx, mwrx, io, ir, pw, ib, h, il;
    {a_op, pcs, wd, sb, ws} = '0;
    {sa, cr, rwr, mrdx, mwrx, io, ir, pw, ib, h, il} = '0;
    if (!r) begin
      case (st)
        0:  begin mrdx = 1; sb = 1; ir = rdy; pw = rdy; end
        1:  sb = 2;
        2:  begin sa = 1; a_op = 2; end
        3:  rwr = 1;
        4:  begin sa = 1; a_op = 1; ib = 1; pcs = 1; end
        5:  begin
              pw = 1; pcs = (op == 5) ? 2'd3 : 2'd2;
              if (op == 4) begin rwr = 1; ws = 1; wd = 2; end
            end
        6:  begin rwr = 1; wd = 1; ws = (op == 6) ? 3'd2 : 3'd3; end
        7:  begin
              if (op == 8) begin rwr = 1; ws = 4; wd = 1; end
              if (op == 9) cr = 1;
            end
        8:  begin sa = 1; sb = 2; end
        9:  begin mrdx = 1; io = 1; end
        10: begin mwrx = 1; io = 1; end
        11: begin rwr = 1; ws = 5; wd = 1; end
        12: h = 1;
        13: il = 1;
        default: ;
      endcase
    end
    return {a_op, sa, sb, ws, wd, cr, rwr, mrdx, mwrx, io, ir, pw, ib, pcs, h, il, done && !r};
  endfunction

  // Compare both instances against the model, then advance the model.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      int st, nxt, op, rc_act;
      bit rdy, adv, last, done;
      logic [23:0] act, exp_v;
      st  = route[d][pos[d]];
      op  = int'(opc[d]);
      rdy = mr[d] | (wait_en[d] == 0);
      if (st == 1 && len[d] == 2 && !rst[d]) build_tail(d, op);
      if (st == 0 || st == 9 || st == 10)  adv = rdy;
      else if (st == 12 || st == 13)       adv = res[d];
      else                                 adv = 1'b1;
      last = (pos[d] + 1 == len[d]);
      done = !rst[d] && adv && last && retires[d];
      nxt  = rst[d] ? 0 : (!adv ? st : (last ? 0 : route[d][pos[d] + 1]));
      act  = {aluop[d], srca[d], srcb[d], wsrc[d], wdest[d], crw[d], rw[d], mrd[d], mwr[d],
              iord[d], irw[d], pcw[d], isbr[d], pcsrc[d], hlt[d], ill[d], idone[d]};
      exp_v = exp_out(st, op, rdy, done, rst[d]);
      rc_act = (d == 0) ? int'(rc0) : int'(rc1);

      ncmp++;
      assert (cs[d] === 4'(st)) else begin
        nerr++; $error("FAIL u%0d current_state obs=%0d exp=%0d", d, cs[d], st);
      end
      ncmp++;
      assert (ns[d] === 4'(nxt)) else begin
        nerr++; $error("FAIL u%0d next_state obs=%0d exp=%0d (st=%0d op=%0d)", d, ns[d], nxt, st, op);
      end
      ncmp++;
      assert (act === exp_v) else begin
        nerr++; $error("FAIL u%0d controls obs=%h exp=%h (st=%0d op=%0d rst=%0b)", d, act, exp_v, st, op, rst[d]);
      end
      ncmp++;
      assert (rc_act === cnt[d]) else begin
        nerr++; $error("FAIL u%0d retired_count obs=%0d exp=%0d", d, rc_act, cnt[d]);
      end

      if (rst[d]) begin
        restart(d); cnt[d] = 0;
      end else if (adv) begin
        if (last) begin
          if (retires[d]) cnt[d] = (cnt[d] + 1) % cmod[d];
          restart(d);
        end else begin
          pos[d]++;
        end
      end
    end
  endtask

  // One directed cycle, same inputs to both; opcode only changes in FETCH.
  task automatic drive(input bit r, input int op, input bit m, input bit s, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
        rst[d] = r; mr[d] = m; res[d] = s;
        if (pos[d] == 0) opc[d] = 6'(op);
      end
      #1 tick();
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; opc[d] = '0; mr[d] = 1'b1; res[d] = 1'b0;
      restart(d); cnt[d] = 0;
    end
    drive(1, 0, 1, 0, 5);          // reset
    drive(0, 0, 1, 0, 4);          // C-type: 0,1,2,3
    drive(0, 10, 1, 0, 3);         // LW: 0,1,8
    drive(0, 10, 0, 0, 3);         // MEMRD waits
    drive(0, 10, 1, 0, 2);         // 9 -> 11
    drive(0, 4, 1, 0, 3);          // JAL
    drive(0, 5, 1, 0, 3);          // JR
    drive(0, 12, 1, 0, 2);         // HALT entry
    drive(0, 12, 1, 0, 4);         // hold halted
    drive(0, 12, 1, 1, 1);         // resume
    drive(0, 13, 1, 0, 5);         // illegal -> TRAP (u0) / NOP (u1)
    drive(0, 13, 1, 1, 1);
    drive(0, 6, 1, 0, 15);         // five LOADIMMs, counter wrap in u1
    drive(0, 11, 1, 0, 3);         // SW: 0,1,8
    drive(0, 11, 0, 0, 2);         // MEMWR waits
    drive(1, 11, 0, 0, 2);         // reset mid-wait
    drive(0, 0, 0, 0, 8);          // no mem_ready: u0 stalls, u1 runs
    drive(0, 0, 1, 0, 2);
    // Randomized traffic, independent per instance.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
        int r;
        rst[d] = ($urandom_range(0, 99) < 2);
        mr[d]  = ($urandom_range(0, 3) != 0);
        res[d] = ($urandom_range(0, 2) == 0);
        if (pos[d] == 0) begin
          r = int'($urandom_range(0, 15));
          opc[d] = (r < 13) ? 6'(r) : 6'($urandom_range(13, 63));
        end
      end
      #1 tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
